// File: rtl/cam_stream_mux_if.sv
// cam_stream_mux_if: per-channel camera input streams plus the muxed output stream.
interface cam_stream_mux_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_sof;
    logic [NUM_CH-1:0]        in_eof;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_sof;
    logic                     out_eof;
    logic [CW-1:0]            out_ch;
    logic                     out_ready;
    modport master (
        output in_data, in_valid, in_sof, in_eof, out_ready,
        input  in_ready, out_data, out_valid, out_sof, out_eof, out_ch
    );
    modport slave (
        input  in_data, in_valid, in_sof, in_eof, out_ready,
        output in_ready, out_data, out_valid, out_sof, out_eof, out_ch
    );
endinterface

// File: rtl/cam_stream_mux.sv
// cam_stream_mux: frame-aware N:1 camera stream mux feeding a show-ahead output FIFO.
// Define CAM_STREAM_MUX_DROP_CNT_EN to build the per-channel dropped-frame counters.
module cam_stream_mux #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int FIFO_DEPTH = 16,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    cam_stream_mux_if.slave      bus,
    input  logic                 cfg_en,
    input  logic                 cfg_mode,
    input  logic [CW-1:0]        cfg_sel,
    output logic [LW-1:0]        fifo_level,
    output logic [NUM_CH*16-1:0] drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = CW + 2 + DATA_W;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PASS = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] sel, last, cand, pch;
    logic          cand_ok, full, empty, start, acc, push, pop;
    logic [AW-1:0] wp, rp;
    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [WW-1:0] head;

    assign full  = fifo_level == LW'(FIFO_DEPTH);
    assign empty = fifo_level == '0;
    assign pop   = !empty && bus.out_ready;

    // Round-robin: scan downward so the nearest channel after last wins.
    always_comb begin
        cand    = cfg_sel;
        cand_ok = (int'(cfg_sel) < NUM_CH) && bus.in_valid[cfg_sel] && bus.in_sof[cfg_sel];
        if (cfg_mode) begin
            cand_ok = 1'b0;
            for (int k = NUM_CH; k >= 1; k--) begin
                if (bus.in_valid[(int'(last) + k) % NUM_CH] && bus.in_sof[(int'(last) + k) % NUM_CH]) begin
                    cand    = CW'((int'(last) + k) % NUM_CH);
                    cand_ok = 1'b1;
                end
            end
        end
    end

    assign start = state == IDLE && cfg_en && cand_ok && !full;
    assign acc   = state == PASS && bus.in_valid[sel] && !full;
    assign push  = start || acc;
    assign pch   = state == IDLE ? cand : sel;

    always_comb begin
        bus.in_ready = '1;
        if (!reset) begin
            if (state == PASS) bus.in_ready[sel] = !full;
            else if (cfg_en && cand_ok) bus.in_ready[cand] = !full;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
            last  <= CW'(NUM_CH - 1);
        end else if (start) begin
            sel <= cand;
            if (bus.in_eof[cand]) last <= cand;
            else state <= PASS;
        end else if (acc && bus.in_eof[sel]) begin
            last  <= sel;
            state <= IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {pch, bus.in_sof[pch], bus.in_eof[pch], bus.in_data[int'(pch)*DATA_W +: DATA_W]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp         <= '0;
            rp         <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

    assign head          = mem[rp];
    assign bus.out_valid = !empty;
    assign bus.out_ch    = head[WW-1 -: CW];
    assign bus.out_sof   = head[DATA_W+1];
    assign bus.out_eof   = head[DATA_W];
    assign bus.out_data  = head[DATA_W-1:0];

`ifdef CAM_STREAM_MUX_DROP_CNT_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_drop
        logic [15:0] cnt;
        always_ff @(posedge clk) begin
            if (reset) cnt <= '0;
            else if (bus.in_valid[i] && bus.in_sof[i] && bus.in_ready[i] && !(push && int'(pch) == i) && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
        assign drop_cnt[i*16 +: 16] = cnt;
    end
`else
    assign drop_cnt = '0;
`endif
endmodule
